// File: rtl/control_arbitro.sv
// control_arbitro: configuration FSM plus round-robin pop arbiter for the four-FIFO output datapath.
module control_arbitro #(
    parameter int UMBRAL_W  = 3,
    parameter int NUM_FIFOS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [UMBRAL_W-1:0]  umbral_bajo_in,
    input  logic [UMBRAL_W-1:0]  umbral_alto_in,
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    input  logic [NUM_FIFOS-1:0] fifo_error,
    input  logic                 pausa,
    output logic                 pop_F0,
    output logic                 pop_F1,
    output logic                 pop_F2,
    output logic                 pop_F3,
    output logic                 push_out,
    output logic [1:0]           sel_out,
    output logic [UMBRAL_W-1:0]  umbral_bajo,
    output logic [UMBRAL_W-1:0]  umbral_alto,
    output logic                 IDLE,
    output logic                 active_out,
    output logic                 error_out,
    output logic [2:0]           state
);
    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_IDLE   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [1:0]          rr_q, sel_q, gidx, cand;
    logic                push_q, found, grant_en, any_err, all_empty;
    logic [UMBRAL_W-1:0] ub_q, ua_q;
    logic [3:0]          pop;

    assign any_err   = |fifo_error;
    assign all_empty = &fifo_empty;
    assign grant_en  = (state_q == S_ACTIVE) & ~pausa & ~any_err & ~all_empty;

    // Search starts just after the last granted FIFO, wrapping mod 4.
    always_comb begin
        found = 1'b0;
        gidx  = rr_q;
        cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_q + 2'(k);
            if (!found && !fifo_empty[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        pop = grant_en ? (4'b0001 << gidx) : 4'b0000;
    end

    always_comb begin
        case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT:   state_d = init ? S_INIT : S_IDLE;
            S_IDLE:   state_d = any_err ? S_ERROR : init ? S_INIT : !all_empty ? S_ACTIVE : S_IDLE;
            S_ACTIVE: state_d = any_err ? S_ERROR : init ? S_INIT : all_empty ? S_IDLE : S_ACTIVE;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            rr_q    <= 2'd3;
            sel_q   <= 2'd0;
            push_q  <= 1'b0;
            ub_q    <= '0;
            ua_q    <= '0;
        end else begin
            state_q <= state_d;
            push_q  <= grant_en;
            if (state_q == S_INIT) begin
                ub_q <= umbral_bajo_in;
                ua_q <= umbral_alto_in;
            end
            if (grant_en) begin
                rr_q  <= gidx;
                sel_q <= gidx;
            end
        end
    end

    assign {pop_F3, pop_F2, pop_F1, pop_F0} = pop;
    assign push_out    = push_q;
    assign sel_out     = sel_q;
    assign umbral_bajo = ub_q;
    assign umbral_alto = ua_q;
    assign IDLE        = state_q == S_IDLE;
    assign active_out  = state_q == S_ACTIVE;
    assign error_out   = state_q == S_ERROR;
    assign state       = state_q;
endmodule

// File: tb/tb_control_arbitro.sv
// tb_control_arbitro: directed plan sequences plus random stimulus against a cycle-level reference model.
module tb_control_arbitro;
    logic       clk = 1'b0;
    logic       reset, init, pausa;
    logic [2:0] umbral_bajo_in, umbral_alto_in;
    logic [3:0] fifo_empty, fifo_error;
    logic       pop_F0, pop_F1, pop_F2, pop_F3, push_out, IDLE, active_out, error_out;
    logic [1:0] sel_out;
    logic [2:0] umbral_bajo, umbral_alto, state;

    int n_chk = 0, n_fail = 0;
    int m_state, m_rr, m_sel, m_push, m_ub, m_ua, m_grant;
    bit m_valid = 0;

    control_arbitro dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_bajo_in(umbral_bajo_in), .umbral_alto_in(umbral_alto_in),
        .fifo_empty(fifo_empty), .fifo_error(fifo_error), .pausa(pausa),
        .pop_F0(pop_F0), .pop_F1(pop_F1), .pop_F2(pop_F2), .pop_F3(pop_F3),
        .push_out(push_out), .sel_out(sel_out),
        .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
        .IDLE(IDLE), .active_out(active_out), .error_out(error_out), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Grant = non-empty FIFO at the smallest forward distance (1..4) from the last grant.
    function automatic int model_grant(input logic [3:0] emp, input logic [3:0] err, input bit pa);
        int best = -1, bd = 5, d;
        if (m_state != 3 || pa || err != 0 || emp == 4'hF) return -1;
        for (int i = 0; i < 4; i++) begin
            d = ((i - m_rr) % 4 + 4) % 4;
            if (d == 0) d = 4;
            if (!emp[i] && d < bd) begin
                bd = d;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic step(input bit r, input bit ini, input int ub, input int ua,
                        input logic [3:0] emp, input logic [3:0] err, input bit pa);
        int exp_pop;
        reset = r; init = ini; umbral_bajo_in = 3'(ub); umbral_alto_in = 3'(ua);
        fifo_empty = emp; fifo_error = err; pausa = pa;
        #1;
        if (m_valid) begin
            m_grant = model_grant(emp, err, pa);
            exp_pop = (m_grant < 0) ? 0 : (1 << m_grant);
            check("state", int'(state), m_state);
            check("pop", int'({pop_F3, pop_F2, pop_F1, pop_F0}), exp_pop);
            check("push_out", int'(push_out), m_push);
            check("sel_out", int'(sel_out), m_sel);
            check("umbral_bajo", int'(umbral_bajo), m_ub);
            check("umbral_alto", int'(umbral_alto), m_ua);
            check("IDLE", int'(IDLE), int'(m_state == 2));
            check("active_out", int'(active_out), int'(m_state == 3));
            check("error_out", int'(error_out), int'(m_state == 4));
        end else m_grant = -1;
        @(posedge clk);
        if (r) begin
            m_state = 0; m_rr = 3; m_sel = 0; m_push = 0; m_ub = 0; m_ua = 0; m_valid = 1;
        end else begin
            if (m_state == 1) begin m_ub = ub; m_ua = ua; end
            m_push = (m_grant >= 0) ? 1 : 0;
            if (m_grant >= 0) begin m_rr = m_grant; m_sel = m_grant; end
            case (m_state)
                0: m_state = 1;
                1: m_state = ini ? 1 : 2;
                2: m_state = (err != 0) ? 4 : ini ? 1 : (emp != 4'hF) ? 3 : 2;
                3: m_state = (err != 0) ? 4 : ini ? 1 : (emp == 4'hF) ? 2 : 3;
                default: m_state = 4;
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Plan 1: configure thresholds and settle in IDLE.
        repeat (2) step(1, 0, 0, 0, 4'hF, 0, 0);
        repeat (4) step(0, 1, 2, 6, 4'hF, 0, 0);
        step(0, 0, 2, 6, 4'hF, 0, 0);
        check("plan1_idle", int'(state), 2);
        check("plan1_ub", int'(umbral_bajo), 2);
        check("plan1_ua", int'(umbral_alto), 6);
        // Plan 2/3/4: full round robin, sparse set, then pausa.
        repeat (6) step(0, 0, 0, 0, 4'h0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 4'hA, 0, 0);
        repeat (2) step(0, 0, 0, 0, 4'h0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 4'h0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 4'h0, 0, 0);
        // Plan 6: drain to IDLE then wake on FIFO3.
        repeat (2) step(0, 0, 0, 0, 4'hF, 0, 0);
        repeat (3) step(0, 0, 0, 0, 4'h7, 0, 0);
        // Plan 5: error is sticky until reset.
        step(0, 0, 0, 0, 4'h0, 4'h4, 0);
        repeat (3) step(0, 1, 5, 5, 4'h0, 0, 0);
        check("plan5_error", int'(error_out), 1);
        step(1, 0, 0, 0, 4'h0, 0, 0);
        step(0, 0, 0, 0, 4'h0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] emp, err;
            emp = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
            err = ($urandom_range(0, 60) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            step($urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 emp, err, $urandom_range(0, 3) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
